// File: rtl/onehot_decoder_hold.sv
// Registered binary-to-one-hot decoder that holds each decoded line for HOLD cycles.
// Define ONEHOT_DECODER_DROP_CNT_EN to add a saturating count of requests refused while busy.
module onehot_decoder_hold #(
   parameter int N    = 2,
   parameter int HOLD = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N-1:0]      in_y,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [2**N-1:0]   y_onehot,
   output logic              out_valid
`ifdef ONEHOT_DECODER_DROP_CNT_EN
   ,
   output logic [7:0]        dropped_count
`endif
);

   localparam int W  = 2**N;
   localparam int CW = $clog2(HOLD + 1);
   localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    y_q, y_d;
   logic            valid_q, valid_d;

   // Next-state decode: accept in IDLE, count down the hold window in HOLD
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      y_d     = y_q;
      valid_d = valid_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d = ST_HOLD;
               y_d     = W'(1'b1) << in_y;
               valid_d = 1'b1;
               cnt_d   = HOLD_M1;
            end else begin
               y_d     = {W{1'b0}};
               valid_d = 1'b0;
            end
         end
         ST_HOLD: begin
            if (cnt_q == {CW{1'b0}}) begin
               state_d = ST_IDLE;
               y_d     = {W{1'b0}};
               valid_d = 1'b0;
            end else begin
               cnt_d   = cnt_q - CW'(1'b1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = {CW{1'b0}};
            y_d     = {W{1'b0}};
            valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset abandons any pending hold
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= {CW{1'b0}};
         y_q     <= {W{1'b0}};
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
         valid_q <= valid_d;
      end
   end

   // Ready depends on state alone so upstream never sees a loop through in_valid
   assign in_ready  = (state_q == ST_IDLE);
   assign y_onehot  = y_q;
   assign out_valid = valid_q;

`ifdef ONEHOT_DECODER_DROP_CNT_EN
   logic [7:0] drop_q, drop_d;

   // Saturating refusal count: a request seen while holding is dropped
   always_comb begin
      drop_d = drop_q;
      if ((state_q == ST_HOLD) && in_valid && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end else begin
         drop_d = drop_q;
      end
   end

   // Refusal counter register, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         drop_q <= 8'd0;
      end else begin
         drop_q <= drop_d;
      end
   end

   assign dropped_count = drop_q;
`endif

endmodule

// File: tb/tb_onehot_decoder_hold.sv
// Self-checking bench for onehot_decoder_hold (N=2, HOLD=4): directed scenarios plus
// randomized traffic compared every cycle against a remaining-cycles reference model.
module tb_onehot_decoder_hold;
   localparam int N    = 2;
   localparam int HOLD = 4;
   localparam int W    = 4;

   logic         clk;
   logic         reset;
   logic [N-1:0] in_y;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] y_onehot;
   logic         out_valid;
`ifdef ONEHOT_DECODER_DROP_CNT_EN
   logic [7:0]   dropped_count;
`endif

   onehot_decoder_hold #(.N(N), .HOLD(HOLD)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_y      (in_y),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .y_onehot  (y_onehot),
      .out_valid (out_valid)
`ifdef ONEHOT_DECODER_DROP_CNT_EN
      ,
      .dropped_count (dropped_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;
   bit mdl_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: number of output cycles still to show, the held index, refusals
   int m_rem  = 0;
   int m_idx  = 0;
   int m_drop = 0;

   always @(posedge clk) begin
      if (reset) begin
         m_rem  = 0;
         m_drop = 0;
      end else if (m_rem == 0) begin
         if (in_valid) begin
            m_rem = HOLD;
            m_idx = int'(in_y);
         end
      end else begin
         if (in_valid && m_drop < 255) m_drop++;
         m_rem--;
      end
   end

   // Per-cycle comparison of the DUT against the model
   always @(negedge clk) begin
      if (mdl_en) begin
         logic [W-1:0] exp_y;
         exp_y = (m_rem > 0) ? W'(1 << m_idx) : {W{1'b0}};
         check("model_y", 32'(y_onehot), 32'(exp_y));
         check("model_valid", 32'(out_valid), 32'(m_rem > 0));
         check("model_ready", 32'(in_ready), 32'(m_rem == 0));
`ifdef ONEHOT_DECODER_DROP_CNT_EN
         check("model_drop", 32'(dropped_count), 32'(m_drop));
`endif
      end
   end

   task automatic wait_ready();
      int t = 0;
      while (in_ready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("ready_timeout", 32'(in_ready), 32'd1);
   endtask

   logic [W-1:0] sweep_tab [4];

   initial begin
      sweep_tab[0] = 4'b0001;
      sweep_tab[1] = 4'b0010;
      sweep_tab[2] = 4'b0100;
      sweep_tab[3] = 4'b1000;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_y     = 2'd0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      mdl_en = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst_y", 32'(y_onehot), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd1);

      // Single decode of index 2
      in_y = 2'd2; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      for (int i = 0; i < HOLD; i++) begin
         @(negedge clk);
         check("single_y", 32'(y_onehot), 32'h4);
         check("single_valid", 32'(out_valid), 32'd1);
         check("single_ready", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      check("single_rel_y", 32'(y_onehot), 32'd0);
      check("single_rel_valid", 32'(out_valid), 32'd0);
      check("single_rel_ready", 32'(in_ready), 32'd1);

      // Index sweep
      for (int v = 0; v < 4; v++) begin
         wait_ready();
         in_y = 2'(v); in_valid = 1'b1;
         @(posedge clk); #1 in_valid = 1'b0;
         for (int i = 0; i < HOLD; i++) begin
            @(negedge clk);
            check("sweep_y", 32'(y_onehot), 32'(sweep_tab[v]));
         end
      end
      @(negedge clk);
      check("sweep_end_y", 32'(y_onehot), 32'd0);

      // Input change during hold, in_valid held high
      in_y = 2'd1; in_valid = 1'b1;
      @(posedge clk); #1 in_y = 2'd3;
      for (int i = 0; i < HOLD; i++) begin
         @(negedge clk);
         check("chg_first_y", 32'(y_onehot), 32'h2);
      end
      @(negedge clk);
      check("chg_gap_y", 32'(y_onehot), 32'd0);
      check("chg_gap_ready", 32'(in_ready), 32'd1);
`ifdef ONEHOT_DECODER_DROP_CNT_EN
      check("drop_four", 32'(dropped_count), 32'd4);
`endif
      for (int i = 0; i < HOLD; i++) begin
         @(negedge clk);
         check("chg_second_y", 32'(y_onehot), 32'h8);
         if (i == HOLD - 1) in_valid = 1'b0;
      end
      @(negedge clk);
      check("chg_end_valid", 32'(out_valid), 32'd0);

      // Reset during hold
      in_y = 2'd3; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      check("rdh_hold1_y", 32'(y_onehot), 32'h8);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("rdh_y", 32'(y_onehot), 32'd0);
      check("rdh_valid", 32'(out_valid), 32'd0);
      check("rdh_ready", 32'(in_ready), 32'd1);
`ifdef ONEHOT_DECODER_DROP_CNT_EN
      check("rdh_drop", 32'(dropped_count), 32'd0);

      // Saturation: ~320 refusals with in_valid held high
      in_valid = 1'b1;
      repeat (400) @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check("drop_sat", 32'(dropped_count), 32'd255);
`endif

      // Randomized traffic with rare resets
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         in_valid = ($urandom_range(0, 99) < 55);
         in_y     = 2'($urandom_range(0, 3));
         reset    = ($urandom_range(0, 99) == 0);
      end
      @(posedge clk); #1 reset = 1'b0; in_valid = 1'b0;
      repeat (HOLD + 2) @(negedge clk);
      check("final_idle_ready", 32'(in_ready), 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/onehot_decoder_hold.md
Name: onehot_decoder_hold

Overview:
- Registered binary-to-one-hot decoder with a minimum-hold timer. It is the consumer end of the priority encoder's (y, valid) output.
- Accepts an index plus a valid flag, drives exactly one output line for HOLD cycles, then releases.
- Back-pressures the upstream via in_ready while a line is being held.
- Typical use: drive indicator LEDs or one-hot enables from priority encoder results.

Parameters:
- N, 2, index width in bits; the output has 2**N lines; N >= 1.
- HOLD, 4, number of cycles each decoded line stays asserted; HOLD >= 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_y  input  N  binary index to decode; sampled only on accept.
- in_valid  input  1  the index is meaningful and a decode is requested.
- in_ready  output  1  block can accept a request this cycle.
- y_onehot  output  2**N  registered one-hot output; all zeros when idle.
- out_valid  output  1  high while y_onehot is driving a line.
- dropped_count  output  8  requests refused while busy; present only with ONEHOT_DECODER_DROP_CNT_EN.

Behaviour:
- One clock (clk). Reset is synchronous and active-high and has priority over every other event.
- Reset values: y_onehot=0, out_valid=0, state=IDLE, hold counter=0, dropped_count=0. in_ready therefore reads 1 from the first cycle after reset.
- States: IDLE and HOLD.
- in_ready = (state==IDLE). It is combinational from state only and must not depend on in_valid.
- Accept occurs at a clock edge where state==IDLE and in_valid==1. On that edge:
  - y_onehot <= 1 << in_y;
  - out_valid <= 1;
  - cnt <= HOLD-1;
  - state <= HOLD.
- Latency from accept edge to output is 1 clock: the output is visible in the cycle after the request is presented.
- IDLE with in_valid==0: no change; outputs stay zero.
- HOLD state, at each edge:
  - if cnt==0: state <= IDLE, y_onehot <= 0, out_valid <= 0;
  - else: cnt <= cnt-1.
- out_valid is high for exactly HOLD consecutive cycles per accepted request.
- in_y and in_valid are ignored during HOLD. The held value must not follow input changes.
- Back-to-back requests: in_valid held high produces HOLD cycles on, 1 cycle off (the IDLE accept cycle), then the next request.
- Counter width is $clog2(HOLD+1). HOLD=1 gives a single-cycle pulse and must work.
- Reset during HOLD: outputs clear on that same edge and the pending hold is abandoned.
- Invariant: y_onehot has exactly one bit set when out_valid==1 and is zero when out_valid==0.
- All outputs are registered except in_ready.

Optional Feature:
- ONEHOT_DECODER_DROP_CNT_EN defined:
  - port dropped_count exists.
  - It increments by 1 on every edge where in_valid==1 and state==HOLD.
  - It saturates at 255 and does not wrap.
  - It clears only on reset.
- Macro undefined:
  - port and counter are absent.
  - Behaviour is otherwise identical.

Test Plan (N=2, HOLD=4):
- Reset check: reset high 2 cycles, then low -> y_onehot=0000, out_valid=0, in_ready=1.
- Single decode: in_y=2, in_valid=1 for one cycle -> next cycle y_onehot=0100, out_valid=1 for exactly 4 cycles, in_ready=0 for those 4 cycles, then all zeros.
- Exhaustive index sweep: for in_y=0..3, one request each, waiting for in_ready -> y_onehot=0001, 0010, 0100, 1000 in order, each held 4 cycles.
- Input change during hold: accept in_y=1, then drive in_y=3 with in_valid=1 throughout -> 0010 held 4 cycles, 1 off cycle, then 1000 for 4 cycles.
- Reset during hold: accept in_y=3, assert reset on the 2nd hold cycle -> y_onehot=0000 and out_valid=0 on the next edge; in_ready=1 afterwards.
- Drop counter (macro on): accept, then keep in_valid=1 through the 4-cycle hold -> dropped_count=4. Repeat beyond 255 refusals -> saturates at 255.
